// File: rtl/exc_redirect_ctrl_pkg.sv
// exc_redirect_ctrl_pkg: state encodings and constants shared by the redirect sequencer.
package exc_redirect_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXC_REDIR = 2'd1;
  localparam logic [1:0] ERET_REDIR = 2'd2;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;
  localparam logic [4:0] CP0_EPC_IDX = 5'd14;
endpackage

// File: rtl/exc_redirect_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/exc_redirect_ctrl.sv
// exc_redirect_ctrl: turns exception acceptance and M-stage ERET into a flush plus a PC redirect
// handshake with fetch, and stalls a D-stage ERET while an EPC write is in flight.
module exc_redirect_ctrl
  import exc_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             int_exc_req,
  input  logic             eret_m,
  input  logic [31:0]      epc,
  input  logic             eret_d,
  input  logic             mtc0_epc_e,
  input  logic             mtc0_epc_m,
  input  logic             redir_ready,
  output logic             kill_m,
  output logic             exl_clr,
  output logic             flush,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  output logic             stall_d,
  output logic             busy,
  output logic [CNT_W-1:0] exc_cnt,
  output logic [CNT_W-1:0] eret_cnt
);
  logic [1:0] state;
  logic [31:0] redir_pc_q;
  logic idle, exc_take, eret_take;
  assign idle = (state == IDLE);
  // exception has priority over a simultaneous ERET
  assign exc_take = idle & int_exc_req;
  assign eret_take = idle & ~int_exc_req & eret_m;
  assign kill_m = exc_take | eret_take;
  assign exl_clr = eret_take;
  assign redir_valid = (state == EXC_REDIR) | (state == ERET_REDIR);
  assign flush = redir_valid;
  assign redir_pc = redir_valid ? redir_pc_q : 32'd0;
  assign stall_d = eret_d & (mtc0_epc_e | mtc0_epc_m);
  assign busy = ~idle;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      redir_pc_q <= '0;
    end else if (exc_take) begin
      state <= EXC_REDIR;
      redir_pc_q <= HANDLER_PC;
    end else if (eret_take) begin
      state <= ERET_REDIR;
      redir_pc_q <= epc;
    end else if (!idle && (redir_ready || !redir_valid)) begin
      state <= IDLE;
    end
  sat_counter #(.W(CNT_W)) u_exc_cnt (.clk(clk), .reset(reset), .inc(exc_take), .count(exc_cnt));
  sat_counter #(.W(CNT_W)) u_eret_cnt (.clk(clk), .reset(reset), .inc(eret_take), .count(eret_cnt));
endmodule
